hdlverifier_capture_controller: RTL and testbench

HDLVERIFIER_CAPTURE_CONTROLLER -- requirements
Module: hdlverifier_capture_controller

---
 rtl/hdlverifier_capture_controller.sv | 122 ++++++++++++
 tb/tb_hdlverifier_capture_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdlverifier_capture_controller.sv
// Triggered capture of a sample stream into a circular buffer, with pre-trigger
// history and a valid/ready readout of one full window per arm.
module hdlverifier_capture_controller #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic [WIDTH-1:0]      data,
    input  logic                  trigger,
    input  logic                  arm,
    input  logic [DEPTH_LOG2-1:0] trigger_position,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_last,
    output logic [2:0]            state,
    output logic                  capture_done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        WAIT_TRIG = 3'd2,
        POSTTRIG  = 3'd3,
        READOUT   = 3'd4
    } state_t;

    state_t cur, nxt;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [WIDTH-1:0]      data_d;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] cnt;
    logic [DEPTH_LOG2-1:0] tpos;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DEPTH_LOG2-1:0] post;

    logic write, hit, fill_done, post_done, load, finish;

    // Post-trigger writes still needed after the trigger sample: DEPTH-1-tpos.
    assign post      = ~tpos;
    assign write     = clk_enable && (cur inside {FILL, WAIT_TRIG, POSTTRIG});
    assign hit       = (cur == WAIT_TRIG) && clk_enable && trigger;
    assign fill_done = (cur == FILL) && clk_enable
                       && (cnt == tpos - DEPTH_LOG2'(1));
    assign post_done = (cur == POSTTRIG) && clk_enable
                       && (cnt == post - DEPTH_LOG2'(1));
    assign load      = (cur == READOUT) && (!rd_valid || (rd_ready && !rd_last));
    assign finish    = rd_valid && rd_ready && rd_last;
    assign state     = cur;

    always_ff @(posedge clk) begin
        if (reset) cur <= IDLE;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:      if (arm) nxt = (trigger_position == '0) ? WAIT_TRIG : FILL;
            FILL:      if (fill_done) nxt = WAIT_TRIG;
            WAIT_TRIG: if (hit) nxt = (&tpos) ? READOUT : POSTTRIG;
            POSTTRIG:  if (post_done) nxt = READOUT;
            READOUT:   if (finish) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (write) mem[wr_ptr] <= data_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_d       <= '0;
            wr_ptr       <= '0;
            cnt          <= '0;
            tpos         <= '0;
            rd_addr      <= '0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            rd_data      <= '0;
            capture_done <= 1'b0;
        end else begin
            capture_done <= finish;
            if (clk_enable) data_d <= data;
            if (write) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            case (cur)
                IDLE: if (arm) begin
                    tpos   <= trigger_position;
                    wr_ptr <= '0;
                    cnt    <= '0;
                end
                FILL: if (clk_enable) cnt <= fill_done ? '0 : cnt + DEPTH_LOG2'(1);
                WAIT_TRIG: if (hit) begin
                    // Window starts tpos samples before the trigger sample.
                    rd_addr <= wr_ptr - tpos;
                    cnt     <= '0;
                end
                POSTTRIG: if (clk_enable) cnt <= post_done ? '0 : cnt + DEPTH_LOG2'(1);
                READOUT: begin
                    if (load) begin
                        rd_data  <= mem[rd_addr];
                        rd_valid <= 1'b1;
                        rd_last  <= &cnt;
                        rd_addr  <= rd_addr + DEPTH_LOG2'(1);
                        cnt      <= cnt + DEPTH_LOG2'(1);
                    end else if (finish) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hdlverifier_capture_controller.sv
// Bench for hdlverifier_capture_controller: directed and randomized captures
// checked against a sample-history model of the expected window.
module tb_hdlverifier_capture_controller;

    localparam int W  = 8;
    localparam int DL = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          reset, clk_enable, trigger, arm, rd_ready;
    logic          rd_valid, rd_last, capture_done;
    logic [W-1:0]  data, rd_data;
    logic [DL-1:0] trigger_position;
    logic [2:0]    state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] dd       = 8'h00;
    logic [7:0] cur_data = 8'h00;
    logic [7:0] stored[$];
    logic [7:0] got[$];

    int         tp_r;
    logic [7:0] s_r, ta_r, tb_r;

    hdlverifier_capture_controller #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
        .clk              (clk),
        .reset            (reset),
        .clk_enable       (clk_enable),
        .data             (data),
        .trigger          (trigger),
        .arm              (arm),
        .trigger_position (trigger_position),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_data          (rd_data),
        .rd_last          (rd_last),
        .state            (state),
        .capture_done     (capture_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle of source stimulus; dd mirrors the sample the block stores now.
    task automatic drive(input bit en, input logic [7:0] ta, input logic [7:0] tb2);
        clk_enable = en;
        trigger    = en ? ((dd == ta) || (dd == tb2)) : 1'($urandom);
        data       = en ? cur_data : 8'($urandom);
        if (en) begin
            stored.push_back(dd);
            dd       = cur_data;
            cur_data = cur_data + 8'd1;
        end
    endtask

    task automatic capture(input logic [7:0] start, input int tp,
                           input logic [7:0] ta, input logic [7:0] tb2,
                           input int smode, input int bmode, input bit xarm);
        logic [7:0] pdata;
        bit         pstall = 0, plast = 0, fin = 0, a2 = 0, a4 = 0, en;
        int         cyc = 0, c_ro = -1, c_v = -1, k = -1;
        bit         lastq[$];
        got.delete();
        cur_data = start;
        @(negedge clk);
        arm              = 1'b1;
        trigger_position = DL'(tp);
        rd_ready         = 1'b0;
        drive(1'b1, ta, tb2);
        trigger = 1'b0;
        stored.delete();
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            arm = 1'b0;
            if (pstall) begin
                chk("hold_valid", rd_valid, 1);
                chk("hold_data", rd_data, pdata);
                chk("hold_last", rd_last, plast);
            end
            if (state == 3'd4 && c_ro < 0) c_ro = cyc;
            if (rd_valid && c_v < 0) c_v = cyc;
            if (capture_done) begin
                fin = 1;
                chk("done_valid_low", rd_valid, 0);
                chk("done_state", state, 0);
            end
            if (bmode == 0)      rd_ready = 1'b1;
            else if (bmode == 1) rd_ready = 1'(cyc % 2);
            else                 rd_ready = ($urandom % 3) != 0;
            if (rd_valid && rd_ready) begin
                got.push_back(rd_data);
                lastq.push_back(rd_last);
            end
            pstall = rd_valid && !rd_ready;
            pdata  = rd_data;
            plast  = rd_last;
            if (xarm && state == 3'd2 && !a2) begin
                arm = 1'b1; a2 = 1; trigger_position = DL'($urandom);
            end
            if (xarm && state == 3'd4 && !a4) begin
                arm = 1'b1; a4 = 1; trigger_position = DL'($urandom);
            end
            if (smode == 0)      en = 1;
            else if (smode == 1) en = (cyc % 2) == 0;
            else                 en = ($urandom % 2) == 0;
            drive(en, ta, tb2);
        end
        arm      = 1'b0;
        rd_ready = 1'b0;
        chk("timeout", fin, 1);
        @(negedge clk);
        chk("done_pulse_once", capture_done, 0);
        chk("idle_after", state, 0);
        chk("first_valid_lat", (c_ro >= 0 && c_v > c_ro && c_v - c_ro <= 2), 1);
        // The trigger sample is the first matching sample past the pre-trigger fill.
        for (int i = tp; i < stored.size(); i++) begin
            if (stored[i] == ta || stored[i] == tb2) begin
                k = i;
                break;
            end
        end
        chk("n_transfers", got.size(), D);
        if (k >= 0 && stored.size() >= k - tp + D && got.size() == D) begin
            for (int j = 0; j < D; j++) begin
                chk("rd_data", got[j], stored[k - tp + j]);
                chk("rd_last", lastq[j], j == D - 1);
            end
        end else begin
            chk("model_window", 0, 1);
        end
    endtask

    task automatic reset_mid(input int target);
        int cyc = 0;
        cur_data = 8'h50;
        @(negedge clk);
        arm              = 1'b1;
        trigger_position = 4'd3;
        rd_ready         = 1'b0;
        drive(1'b1, 8'h58, 8'h58);
        trigger = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            arm = 1'b0;
            if (state == 3'(target) && (target != 4 || rd_valid)) break;
            drive(1'b1, 8'h58, 8'h58);
        end while (cyc < 200);
        chk("reach_state", state, target);
        reset = 1'b1;
        drive(1'b1, 8'h58, 8'h58);
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_last", rd_last, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_done", capture_done, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        clk_enable       = 1'b0;
        data             = '0;
        trigger          = 1'b0;
        arm              = 1'b0;
        trigger_position = '0;
        rd_ready         = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_state", state, 0);
        chk("init_valid", rd_valid, 0);
        chk("init_last", rd_last, 0);
        chk("init_data", rd_data, 0);
        chk("init_done", capture_done, 0);
        reset      = 1'b0;
        clk_enable = 1'b1;

        capture(8'h10, 4, 8'h20, 8'h20, 0, 0, 0);
        chk("nom_first", got[0], 8'h1C);
        chk("nom_last", got[15], 8'h2B);

        capture(8'h10, 4, 8'h20, 8'h11, 0, 0, 0);
        chk("early_first", got[0], 8'h1C);
        chk("early_last", got[15], 8'h2B);

        capture(8'h00, 0, 8'h05, 8'h05, 0, 0, 0);
        chk("zero_first", got[0], 8'h05);
        chk("zero_last", got[15], 8'h14);

        capture(8'h30, 15, 8'h40, 8'h40, 0, 0, 0);
        chk("full_pre_first", got[0], 8'h31);
        chk("full_pre_trig", got[15], 8'h40);

        capture(8'h10, 4, 8'h20, 8'h20, 1, 1, 0);
        chk("stall_first", got[0], 8'h1C);
        chk("stall_last", got[15], 8'h2B);

        capture(8'h10, 4, 8'h20, 8'h20, 0, 0, 1);
        chk("xarm_first", got[0], 8'h1C);
        chk("xarm_last", got[15], 8'h2B);

        reset_mid(3);
        reset_mid(4);
        capture(8'h10, 4, 8'h20, 8'h20, 0, 0, 0);
        chk("after_rst_first", got[0], 8'h1C);

        for (int r = 0; r < 12; r++) begin
            tp_r = int'($urandom % 16);
            s_r  = 8'($urandom);
            ta_r = s_r + 8'(tp_r) + 8'($urandom % 20);
            tb_r = (tp_r > 0) ? s_r + 8'($urandom % tp_r) : ta_r;
            capture(s_r, tp_r, ta_r, tb_r, 2, 2, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
